// File: rtl/tick_scheduler.sv
// Shared prescaler plus N_CH programmable tick channels handing out one-cycle enables.
// Ticks are registered one cycle after the base tick; config writes stall while the target channel runs.
module tick_scheduler #(
  parameter int BASE_DIV = 50_000,
  parameter int N_CH     = 4,
  parameter int PER_W    = 16,
  parameter int CH_W     = 2
) (
  input  logic              C_50Mhz,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic              cfg_mode,
  input  logic [N_CH-1:0]   ch_start,
  input  logic [N_CH-1:0]   ch_stop,
  output logic              base_tick,
  output logic [N_CH-1:0]   ch_tick,
  output logic [N_CH-1:0]   ch_busy,
  output logic [N_CH-1:0]   ch_done
);

  localparam int PRE_W = $clog2(BASE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge C_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      base_tick <= 1'b0;
    end else begin
      if (pre_q == PRE_LAST) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      // Registered so the pulse lines up with the cycle the counter sits at its last value.
      base_tick <= (pre_q == PRE_LAST - 1'b1);
    end
  end

  // Channel indices beyond N_CH read as busy, which blocks writes to them.
  logic [(1 << CH_W)-1:0] busy_ext;

  always_comb begin
    busy_ext             = '1;
    busy_ext[N_CH-1:0]   = ch_busy;
  end

  assign cfg_ready = ~busy_ext[cfg_ch];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [PER_W-1:0]  period_q, cnt_q, eff_per, load_val;
    logic              mode_q, tick_q, wr, start, fire, busy_c, done_c;

    always_comb begin
      wr       = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      start    = ch_start[i] && !ch_stop[i];
      // A write landing with the start supplies the period for that start.
      eff_per  = wr ? cfg_period : period_q;
      load_val = (eff_per == '0) ? PER_W'(1) : eff_per;
      fire     = (state_q == S_RUN) && base_tick && (cnt_q == PER_W'(1)) && !ch_stop[i];
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (ch_stop[i])          state_d = S_IDLE;
          else if (fire && mode_q) state_d = S_DONE;
        end
        S_DONE: begin
          if (start)                          state_d = S_RUN;
          else if (ch_start[i] && ch_stop[i]) state_d = S_IDLE;
          else if (wr)                        state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge C_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        period_q <= PER_W'(1);
        mode_q   <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        tick_q  <= fire;
        if (wr) begin
          period_q <= cfg_period;
          mode_q   <= cfg_mode;
        end
        if (state_q != S_RUN && state_d == S_RUN) begin
          cnt_q <= load_val;
        end else if (state_q == S_RUN && base_tick) begin
          cnt_q <= (cnt_q == PER_W'(1)) ? load_val : cnt_q - 1'b1;
        end
      end
    end

    always_comb begin
      busy_c = (state_q == S_RUN);
      done_c = (state_q == S_DONE);
    end

    assign ch_busy[i] = busy_c;
    assign ch_done[i] = done_c;
    assign ch_tick[i] = tick_q;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
Shared timebase controller for the board's 50 MHz clock domain. One free-running prescaler produces a base tick. N_CH independent channels each count a programmable number of base ticks and emit single-cycle enable pulses, either periodic or one-shot. It replaces per-consumer clock dividers, such as LED blink and display refresh, with one configurable scheduler that hands out timed enables instead of derived clocks.

Parameters:
BASE_DIV, 50_000, system clocks per base tick (1 kHz at 50 MHz); legal range >= 2
N_CH, 4, number of channels
PER_W, 16, width of channel period in base ticks
CH_W, 2, width of channel index, equal to clog2(N_CH)

Ports:
C_50Mhz  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration write request
cfg_ready  out  1  configuration write can be accepted
cfg_ch  in  CH_W  target channel of the configuration write
cfg_period  in  PER_W  period in base ticks
cfg_mode  in  1  0 = periodic, 1 = one-shot
ch_start  in  N_CH  per-channel start request, level-sampled each cycle
ch_stop  in  N_CH  per-channel stop request, level-sampled each cycle
base_tick  out  1  one-cycle pulse every BASE_DIV clocks
ch_tick  out  N_CH  one-cycle channel enable pulse
ch_busy  out  N_CH  channel is in RUN
ch_done  out  N_CH  sticky flag: one-shot channel has completed

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronous): prescaler = 0; all channels go to IDLE; period registers = 1; mode = periodic.
- Output values in reset: base_tick, ch_tick, ch_busy and ch_done = 0; cfg_ready = 1.
- Prescaler: counts 0..BASE_DIV-1 and wraps to 0.
  - base_tick is registered and high for exactly the one cycle in which the counter equals BASE_DIV-1.
  - The first base_tick occurs in cycle BASE_DIV after reset release; after that, every BASE_DIV cycles.
  - Free-running; never stalled by channel activity.
- Config handshake:
  - cfg_ready = ~ch_busy[cfg_ch], combinational.
  - A write is accepted on an edge where cfg_valid && cfg_ready. It loads period[cfg_ch] and mode[cfg_ch] and clears ch_done[cfg_ch].
  - When ready is low, the write has no effect; the requester holds it.
  - cfg_ch >= N_CH: cfg_ready = 0, write ignored.
  - cfg_period = 0 is stored as 0 and behaves as 1.
- Channel FSM, one per channel, states IDLE / RUN / DONE:
  - IDLE or DONE -> RUN when ch_start[i]=1 and ch_stop[i]=0. On entry: down-counter = max(period,1), ch_done[i] = 0.
  - RUN -> IDLE when ch_stop[i]=1. Takes effect at the next edge; no tick is emitted; the counter is discarded.
  - ch_start[i] while in RUN is ignored: no restart, no phase change.
  - ch_start and ch_stop in the same cycle: stop wins; a channel not in RUN stays or goes to IDLE.
  - In RUN, each base_tick decrements the counter.
  - When a base_tick finds counter == 1, ch_tick[i] is pulsed for one cycle in the next cycle (registered, one-cycle latency after that base_tick). Then:
    - periodic: counter reloads with max(period,1); stay in RUN.
    - one-shot: -> DONE. In the same cycle as the tick, ch_busy[i] falls and ch_done[i] rises.
  - ch_stop in the same cycle as the completing base_tick: stop wins; no tick is emitted.
  - Counting is phase-locked to the shared prescaler, not to the start edge. Start-to-first-tick latency is between (P-1)*BASE_DIV+2 and P*BASE_DIV+1 cycles.
- ch_busy[i] = (state == RUN), registered. ch_done[i] = (state == DONE), registered.
- A config write and a ch_start to the same idle channel in the same cycle: the new period and mode are used for that start.
- Channels are fully independent; any number of them may tick in the same cycle.

Test Plan:
- Bench parameters: BASE_DIV=4, N_CH=4, PER_W=16.
- Reset release -> base_tick high in cycles 4, 8, 12, ...; all ch_* outputs 0; cfg_ready=1.
- Config ch0 period=3 periodic, then pulse ch_start[0] -> ch_busy[0]=1; ch_tick[0] pulses exactly every 12 cycles, each one cycle after a base_tick; ch_done[0] stays 0.
- Config ch1 period=2 one-shot, then start -> one ch_tick[1] only. In that cycle ch_busy[1] goes 0 and ch_done[1] goes 1 and stays 1. A second ch_start[1] clears done and yields one more tick.
- Stop ch0 mid-period -> ch_busy[0]=0 next cycle, no further ch_tick[0]. ch_start[2] and ch_stop[2] together -> ch2 stays IDLE.
- Config ch0 while running -> cfg_ready=0; period unchanged (ticks still every 12 cycles). Config ch3 period=0, then start -> ch_tick[3] on every base tick.
- rst_n low mid-run with ch0 and ch1 active -> all outputs 0 immediately, before the next clock edge. After release, base_tick phase restarts (first pulse 4 cycles later) and period registers read back as 1.
